is_dispatch_queue: RTL and testbench

//  Parametrised, multi-wide successor to the single-slot issue front end.

---
 rtl/is_dispatch_queue.sv | 210 +++++++++++++++++++++
 tb/tb_is_dispatch_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/is_dispatch_queue.sv
// -----------------------------------------------------------------------------
// is_dispatch_queue
//   Circular instruction queue between fetch and RS/ROB allocation.
//   Accepts up to WIDTH fetched instructions per cycle and dispatches up to
//   WIDTH per cycle in strict program order. Dispatch is limited by ROB free
//   slots and by per-class (ALU / ACU load-store) reservation-station free
//   counts. A dispatched WFI puts the block into a sticky halt.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   flush             empties the queue (branch mispredict); halt is kept
//   in_valid/inst/pc  fetch group, lane k in bits [32k+31:32k]
//   in_ready          a full WIDTH group fits (based on registered count)
//   rob_free_cnt      free ROB entries this cycle
//   rs_free_alu/acu   free RS entries per functional-unit class
//   disp_valid        thermometer-coded dispatch lanes
//   disp_inst/pc      dispatched instruction / PC per lane
//   disp_is_acu       1 = load/store class, 0 = ALU class (valid lanes only)
//   halted            set the cycle after WFI dispatches, held until reset
//   q_count           occupied entries
// -----------------------------------------------------------------------------
module is_dispatch_queue #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          in_valid,
    input  logic [WIDTH*32-1:0]       in_inst,
    input  logic [WIDTH*32-1:0]       in_pc,
    output logic                      in_ready,
    input  logic [CNT_W-1:0]          rob_free_cnt,
    input  logic [CNT_W-1:0]          rs_free_alu,
    input  logic [CNT_W-1:0]          rs_free_acu,
    output logic [WIDTH-1:0]          disp_valid,
    output logic [WIDTH*32-1:0]       disp_inst,
    output logic [WIDTH*32-1:0]       disp_pc,
    output logic [WIDTH-1:0]          disp_is_acu,
    output logic                      halted,
    output logic [$clog2(DEPTH):0]    q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int QW    = PTR_W + 1;

    localparam logic [QW-1:0] DEPTH_Q   = QW'(DEPTH);
    localparam logic [QW-1:0] WIDTH_Q   = QW'(WIDTH);
    localparam logic [31:0]   WFI_INST  = 32'h1050_0073;
    localparam logic [6:0]    OPC_LOAD  = 7'b000_0011;
    localparam logic [6:0]    OPC_STORE = 7'b010_0011;

    // Load/store opcodes go to the ACU; everything else (including WFI) is ALU.
    function automatic logic f_is_acu(input logic [31:0] inst);
        return (inst[6:0] == OPC_LOAD) || (inst[6:0] == OPC_STORE);
    endfunction

    function automatic logic [QW-1:0] f_popcount(input logic [WIDTH-1:0] vec);
        logic [QW-1:0] cnt;
        cnt = {QW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + QW'(vec[i]);
        end
        return cnt;
    endfunction

    // Queue storage and control state
    logic [31:0]       r_inst [DEPTH];
    logic [31:0]       r_pc   [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [QW-1:0]     r_count;
    logic              r_halted;

    // Combinational signals
    logic [WIDTH-1:0]    w_disp_valid;
    logic [WIDTH*32-1:0] w_disp_inst;
    logic [WIDTH*32-1:0] w_disp_pc;
    logic [WIDTH-1:0]    w_disp_is_acu;
    logic                w_wfi_fire;
    logic                w_in_ready;
    logic                w_enq_fire;
    logic [QW-1:0]       w_enq_add;
    logic [QW-1:0]       w_deq_num;
    logic [PTR_W-1:0]    w_wr_idx [WIDTH];

    // Acceptance uses only the registered count: same-cycle dispatch frees nothing.
    assign w_in_ready = ((DEPTH_Q - r_count) >= WIDTH_Q);
    assign w_enq_fire = (|in_valid) && w_in_ready && !flush && !reset;
    assign w_enq_add  = w_enq_fire ? f_popcount(in_valid) : {QW{1'b0}};
    assign w_deq_num  = f_popcount(w_disp_valid);

    // In-order dispatch selection: first failing candidate blocks all later lanes.
    always_comb begin : p_dispatch
        logic             v_blocked;
        logic [CNT_W-1:0] v_alu_used;
        logic [CNT_W-1:0] v_acu_used;
        logic [PTR_W-1:0] v_idx;
        logic [31:0]      v_inst;
        logic             v_acu_cls;
        logic             v_is_wfi;
        logic             v_class_ok;
        logic             v_ok;
        w_disp_valid  = {WIDTH{1'b0}};
        w_disp_inst   = {(WIDTH*32){1'b0}};
        w_disp_pc     = {(WIDTH*32){1'b0}};
        w_disp_is_acu = {WIDTH{1'b0}};
        w_wfi_fire    = 1'b0;
        v_blocked     = reset || flush || r_halted;
        v_alu_used    = {CNT_W{1'b0}};
        v_acu_used    = {CNT_W{1'b0}};
        v_idx         = {PTR_W{1'b0}};
        v_inst        = 32'h0000_0000;
        v_acu_cls     = 1'b0;
        v_is_wfi      = 1'b0;
        v_class_ok    = 1'b0;
        v_ok          = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            v_idx     = r_head + PTR_W'(k);
            v_inst    = r_inst[v_idx];
            v_acu_cls = f_is_acu(v_inst);
            v_is_wfi  = (v_inst == WFI_INST);
            w_disp_inst[32*k +: 32] = v_inst;
            w_disp_pc[32*k +: 32]   = r_pc[v_idx];
            if (v_acu_cls) begin
                v_class_ok = (rs_free_acu > v_acu_used);
            end else begin
                v_class_ok = (rs_free_alu > v_alu_used);
            end
            // WFI may only go out alone in lane 0.
            v_ok = !v_blocked
                && (QW'(k) < r_count)
                && (rob_free_cnt > CNT_W'(k))
                && v_class_ok
                && !(v_is_wfi && (k != 0));
            if (v_ok) begin
                w_disp_valid[k]  = 1'b1;
                w_disp_is_acu[k] = v_acu_cls;
                if (v_acu_cls) begin
                    v_acu_used = v_acu_used + CNT_W'(1);
                end else begin
                    v_alu_used = v_alu_used + CNT_W'(1);
                end
                if (v_is_wfi) begin
                    w_wfi_fire = 1'b1;
                    v_blocked  = 1'b1;
                end else begin
                    v_blocked  = v_blocked;
                end
            end else begin
                v_blocked = 1'b1;
            end
        end
    end

    // Write slot per lane: valid lanes are compacted in lane order from tail.
    always_comb begin : p_wr_idx
        logic [PTR_W-1:0] v_off;
        v_off = {PTR_W{1'b0}};
        for (int k = 0; k < WIDTH; k++) begin
            w_wr_idx[k] = r_tail + v_off;
            if (in_valid[k]) begin
                v_off = v_off + PTR_W'(1);
            end else begin
                v_off = v_off;
            end
        end
    end

    // Queue payload storage; contents are don't-care outside head..tail.
    always_ff @(posedge clock) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (w_enq_fire && in_valid[k]) begin
                r_inst[w_wr_idx[k]] <= in_inst[32*k +: 32];
                r_pc[w_wr_idx[k]]   <= in_pc[32*k +: 32];
            end
        end
    end

    // Pointer, occupancy and halt state; flush clears the queue but keeps halt.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head   <= {PTR_W{1'b0}};
            r_tail   <= {PTR_W{1'b0}};
            r_count  <= {QW{1'b0}};
            r_halted <= 1'b0;
        end else if (flush) begin
            r_head   <= {PTR_W{1'b0}};
            r_tail   <= {PTR_W{1'b0}};
            r_count  <= {QW{1'b0}};
        end else begin
            r_head  <= r_head + w_deq_num[PTR_W-1:0];
            r_tail  <= r_tail + w_enq_add[PTR_W-1:0];
            r_count <= r_count + w_enq_add - w_deq_num;
            if (w_wfi_fire) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign disp_valid  = w_disp_valid;
    assign disp_inst   = w_disp_inst;
    assign disp_pc     = w_disp_pc;
    assign disp_is_acu = w_disp_is_acu;
    assign halted      = r_halted;
    assign q_count     = r_count;

endmodule

// File: tb/tb_is_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_is_dispatch_queue
//   Directed self-checking bench for is_dispatch_queue (WIDTH=2, DEPTH=8).
//   Inputs change on the falling edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_is_dispatch_queue;

    localparam logic [31:0] ADD = 32'h0020_81b3;
    localparam logic [31:0] LW  = 32'h0000_a183;
    localparam logic [31:0] SW  = 32'h0030_a023;
    localparam logic [31:0] WFI = 32'h1050_0073;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_inst;
    logic [63:0] in_pc;
    logic        in_ready;
    logic [3:0]  rob_free_cnt;
    logic [3:0]  rs_free_alu;
    logic [3:0]  rs_free_acu;
    logic [1:0]  disp_valid;
    logic [63:0] disp_inst;
    logic [63:0] disp_pc;
    logic [1:0]  disp_is_acu;
    logic        halted;
    logic [3:0]  q_count;

    int n_pass;
    int n_total;

    is_dispatch_queue #(.WIDTH(2), .DEPTH(8), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .in_ready     (in_ready),
        .rob_free_cnt (rob_free_cnt),
        .rs_free_alu  (rs_free_alu),
        .rs_free_acu  (rs_free_acu),
        .disp_valid   (disp_valid),
        .disp_inst    (disp_inst),
        .disp_pc      (disp_pc),
        .disp_is_acu  (disp_is_acu),
        .halted       (halted),
        .q_count      (q_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1);
        in_valid = v;
        in_inst  = {i1, i0};
        in_pc    = {p1, p0};
    endtask

    task automatic frees(input logic [3:0] rob, input logic [3:0] alu, input logic [3:0] acu);
        rob_free_cnt = rob;
        rs_free_alu  = alu;
        rs_free_acu  = acu;
    endtask

    // Advance to the next falling edge (inputs change there).
    task automatic cyc();
        @(negedge clock);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        flush   = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        frees(4'd0, 4'd0, 4'd0);
        cyc(); cyc();

        // Reset state
        reset = 1'b0;
        #1;
        chk("rst_q_count", 64'(q_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_disp_valid", 64'(disp_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);

        // 1. Two ADDs dispatch together the cycle after enqueue
        cyc();
        drive(2'b11, ADD, 32'h100, ADD, 32'h104);
        frees(4'd4, 4'd4, 4'd4);
        #1;
        chk("t1_empty_disp", 64'(disp_valid), 64'd0);
        cyc();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("t1_disp_valid", 64'(disp_valid), 64'd3);
        chk("t1_is_acu", 64'(disp_is_acu), 64'd0);
        chk("t1_disp_pc", disp_pc, {32'h104, 32'h100});
        chk("t1_q_before", 64'(q_count), 64'd2);
        cyc();
        #1;
        chk("t1_q_after", 64'(q_count), 64'd0);

        // 2. LW,LW limited by ACU RS space
        cyc();
        drive(2'b11, LW, 32'h200, LW, 32'h204);
        frees(4'd4, 4'd4, 4'd0);
        cyc();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("t2_acu0_disp", 64'(disp_valid), 64'd0);
        chk("t2_acu0_q", 64'(q_count), 64'd2);
        cyc();
        frees(4'd4, 4'd4, 4'd1);
        #1;
        chk("t2_lw1_disp", 64'(disp_valid), 64'd1);
        chk("t2_lw1_pc", 64'(disp_pc[31:0]), 64'h200);
        chk("t2_lw1_acu", 64'(disp_is_acu), 64'd1);
        cyc();
        #1;
        chk("t2_lw2_disp", 64'(disp_valid), 64'd1);
        chk("t2_lw2_pc", 64'(disp_pc[31:0]), 64'h204);
        chk("t2_lw2_q", 64'(q_count), 64'd1);

        // 3. ADD,SW limited by one ROB slot
        cyc();
        drive(2'b11, ADD, 32'h300, SW, 32'h304);
        frees(4'd1, 4'd4, 4'd4);
        cyc();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("t3_add_disp", 64'(disp_valid), 64'd1);
        chk("t3_add_pc", 64'(disp_pc[31:0]), 64'h300);
        chk("t3_add_acu", 64'(disp_is_acu), 64'd0);
        cyc();
        #1;
        chk("t3_sw_disp", 64'(disp_valid), 64'd1);
        chk("t3_sw_pc", 64'(disp_pc[31:0]), 64'h304);
        chk("t3_sw_acu", 64'(disp_is_acu), 64'd1);

        // 4. Fill to DEPTH with no frees, then drain across the wrap
        for (int g = 0; g < 4; g++) begin
            cyc();
            drive(2'b11, ADD, 32'h400 + 32'(8*g), ADD, 32'h404 + 32'(8*g));
            frees(4'd0, 4'd0, 4'd0);
            #1;
            chk("t4_fill_ready", 64'(in_ready), 64'd1);
            chk("t4_fill_q", 64'(q_count), 64'(2*g));
        end
        cyc();
        drive(2'b11, ADD, 32'h500, ADD, 32'h504);
        #1;
        chk("t4_full_ready", 64'(in_ready), 64'd0);
        chk("t4_full_q", 64'(q_count), 64'd8);
        chk("t4_full_disp", 64'(disp_valid), 64'd0);
        cyc();
        drive(2'b11, ADD, 32'h510, ADD, 32'h514);
        frees(4'd4, 4'd4, 4'd4);
        #1;
        chk("t4_ign_q", 64'(q_count), 64'd8);
        chk("t4_drain_ready", 64'(in_ready), 64'd0);
        chk("t4_drain0_disp", 64'(disp_valid), 64'd3);
        chk("t4_drain0_pc", disp_pc, {32'h404, 32'h400});
        for (int d = 1; d < 4; d++) begin
            cyc();
            drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            #1;
            chk("t4_drain_disp", 64'(disp_valid), 64'd3);
            chk("t4_drain_pc", disp_pc, {32'h404 + 32'(8*d), 32'h400 + 32'(8*d)});
            chk("t4_drain_q", 64'(q_count), 64'(8 - 2*d));
        end
        cyc();
        #1;
        chk("t4_empty_q", 64'(q_count), 64'd0);
        chk("t4_empty_ready", 64'(in_ready), 64'd1);

        // 6. Flush at q_count=5 with a same-cycle input group
        cyc();
        frees(4'd0, 4'd0, 4'd0);
        drive(2'b11, ADD, 32'h600, ADD, 32'h604);
        cyc();
        drive(2'b11, ADD, 32'h608, ADD, 32'h60C);
        cyc();
        drive(2'b10, ADD, 32'h610, ADD, 32'h614);
        cyc();
        drive(2'b11, ADD, 32'h618, ADD, 32'h61C);
        flush = 1'b1;
        frees(4'd4, 4'd4, 4'd4);
        #1;
        chk("t6_pre_q", 64'(q_count), 64'd5);
        chk("t6_flush_disp", 64'(disp_valid), 64'd0);
        cyc();
        flush = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        frees(4'd0, 4'd0, 4'd0);
        #1;
        chk("t6_post_q", 64'(q_count), 64'd0);
        chk("t6_post_disp", 64'(disp_valid), 64'd0);
        chk("t6_post_ready", 64'(in_ready), 64'd1);

        // Compaction: only lane 1 valid lands in the tail slot
        cyc();
        drive(2'b10, LW, 32'h6F0, ADD, 32'h700);
        cyc();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        frees(4'd4, 4'd4, 4'd4);
        #1;
        chk("cmp_q", 64'(q_count), 64'd1);
        chk("cmp_disp", 64'(disp_valid), 64'd1);
        chk("cmp_pc", 64'(disp_pc[31:0]), 64'h700);
        chk("cmp_inst", 64'(disp_inst[31:0]), 64'(ADD));

        // 5. ADD,WFI then ADD: WFI goes alone, then sticky halt
        cyc();
        drive(2'b11, ADD, 32'h800, WFI, 32'h804);
        cyc();
        drive(2'b01, ADD, 32'h808, 32'h0, 32'h0);
        #1;
        chk("t5_c1_disp", 64'(disp_valid), 64'd1);
        chk("t5_c1_pc", 64'(disp_pc[31:0]), 64'h800);
        chk("t5_c1_halted", 64'(halted), 64'd0);
        cyc();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("t5_c2_disp", 64'(disp_valid), 64'd1);
        chk("t5_c2_inst", 64'(disp_inst[31:0]), 64'(WFI));
        chk("t5_c2_pc", 64'(disp_pc[31:0]), 64'h804);
        chk("t5_c2_q", 64'(q_count), 64'd2);
        cyc();
        drive(2'b11, ADD, 32'h80C, ADD, 32'h810);
        #1;
        chk("t5_halted", 64'(halted), 64'd1);
        chk("t5_halt_disp", 64'(disp_valid), 64'd0);
        chk("t5_halt_q", 64'(q_count), 64'd1);
        chk("t5_halt_ready", 64'(in_ready), 64'd1);
        cyc();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("t5_enq_q", 64'(q_count), 64'd3);
        chk("t5_still_halt", 64'(disp_valid), 64'd0);

        // Reset clears halt and queue
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("rst2_halted", 64'(halted), 64'd0);
        chk("rst2_q", 64'(q_count), 64'd0);
        chk("rst2_disp", 64'(disp_valid), 64'd0);
        chk("rst2_ready", 64'(in_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
